axi_read_master: RTL

AXI_READ_MASTER -- requirements
Module: axi_read_master

---
 rtl/axi_read_master.sv | 135 +++++++++++++
 1 files changed

// File: rtl/axi_read_master.sv
// Single-burst AXI4 read master: command -> AR handshake -> R beats forwarded to a stream.
// Define AXI_READ_MASTER_RLAST_CHECK_EN to end bursts on beat count and flag rlast mismatches.
module axi_read_master #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     aclk,
    input  logic                     rst,
    // Command
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [7:0]               cmd_len,
    // Read address channel
    output logic [ADDRESS_WIDTH-1:0] araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    output logic                     arvalid,
    input  logic                     arready,
    // Read data channel
    input  logic [DATA_WIDTH-1:0]    rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    // Output stream
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    // Status
    output logic                     done,
    output logic                     err,
    output logic [1:0]               dbg_state
);

    // Every channel uses valid/ready: a transfer happens on a rising edge where both are 1;
    // the sender holds payload stable while valid is high and ready is low.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [2:0] ARSIZE = 3'($clog2(DATA_WIDTH / 8));

    state_t                   r_state;
    state_t                   w_next;
    logic [ADDRESS_WIDTH-1:0] r_araddr;
    logic [7:0]               r_arlen;
    logic [7:0]               r_beat_cnt;
    logic                     r_done;
    logic                     r_err;

    logic w_accept;
    logic w_ar_hs;
    logic w_beat;
    logic w_final;
    logic w_beat_err;

    assign w_accept = (r_state == IDLE) && cmd_valid;
    assign w_ar_hs  = (r_state == ADDR) && arready;
    assign w_beat   = (r_state == DATA) && rvalid && out_ready;

`ifdef AXI_READ_MASTER_RLAST_CHECK_EN
    logic w_cnt_last;
    assign w_cnt_last = (r_beat_cnt == r_arlen);
    assign w_final    = w_beat && w_cnt_last;
    // Early rlast and missing rlast on the counted last beat are both protocol errors.
    assign w_beat_err = w_beat && ((rresp != 2'b00) || (rlast != w_cnt_last));
`else
    assign w_final    = w_beat && rlast;
    assign w_beat_err = w_beat && (rresp != 2'b00);
`endif

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = ADDR;
            ADDR:    if (w_ar_hs)  w_next = DATA;
            DATA:    if (w_final)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_beat_cnt <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_final;
            if (w_beat_err) begin
                r_err <= 1'b1;
            end
            if (w_accept) begin
                r_araddr <= cmd_addr;
                r_arlen  <= cmd_len;
            end
            if (w_ar_hs) begin
                r_beat_cnt <= '0;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end

    // cmd_ready is gated by rst so a command cannot be lost during the reset cycle.
    assign cmd_ready = (r_state == IDLE) && !rst;
    assign araddr    = r_araddr;
    assign arlen     = r_arlen;
    assign arsize    = ARSIZE;
    assign arburst   = 2'b01;
    assign arvalid   = (r_state == ADDR);
    assign rready    = (r_state == DATA) && out_ready;
    assign out_data  = rdata;
    assign out_last  = (r_state == DATA) && rlast;
    assign out_valid = (r_state == DATA) && rvalid;
    assign done      = r_done;
    assign err       = r_err;
    assign dbg_state = r_state;

endmodule
